// File: rtl/mkr_parallel_rx.sv
// ---------------------------------------------------------------------------
// mkr_parallel_rx
//
// Receive stage between the SAM D21 MCU and the Cicero user logic. The MCU
// presents bytes on the MKR header with an asynchronous 4-phase strobe/ack
// handshake. This block synchronises the strobe, captures each byte, packs
// bytes little-endian into words and buffers the words in a show-ahead FIFO
// that feeds the regex engine loader over valid/ready.
//
// Ports
//   clk            system clock (48 MHz domain)
//   reset          synchronous, active-high reset
//   i_mkr_data     byte from MCU, stable from strobe rise until ack rise
//   i_mkr_stb      asynchronous strobe from MCU, high = byte presented
//   o_mkr_ack      acknowledge to MCU
//   i_flush        single-cycle pulse: emit any partially packed word
//   o_word_data    FIFO head word (zero while empty)
//   o_word_keep    byte-valid mask of the head word (zero while empty)
//   o_word_valid   FIFO not empty
//   i_word_ready   consumer accepts the head word
//   o_fifo_level   current FIFO occupancy
// ---------------------------------------------------------------------------
module mkr_parallel_rx #(
   parameter int SYNC_STAGES = 2,   // strobe synchroniser depth, >= 2
   parameter int WORD_BYTES  = 4,   // bytes per output word, >= 2
   parameter int FIFO_DEPTH  = 16   // power of two, >= 2
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [7:0]                    i_mkr_data,
   input  logic                          i_mkr_stb,
   output logic                          o_mkr_ack,
   input  logic                          i_flush,
   output logic [8*WORD_BYTES-1:0]       o_word_data,
   output logic [WORD_BYTES-1:0]         o_word_keep,
   output logic                          o_word_valid,
   input  logic                          i_word_ready,
   output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
);

   localparam int WW    = 8 * WORD_BYTES;
   localparam int IDX_W = $clog2(WORD_BYTES + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int LVL_W = PTR_W + 1;
   localparam int SET_W = $clog2(SYNC_STAGES + 1);

   typedef enum logic [1:0] {
      ST_RESYNC,
      ST_IDLE,
      ST_ACK
   } state_e;

   // ------------------------------------------------------------------
   // Strobe synchroniser
   // ------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] stb_sync_q;
   logic                   stb_s;
   logic [SET_W-1:0]       settle_q, settle_d;
   logic                   settled;

   assign stb_s   = stb_sync_q[SYNC_STAGES-1];
   // The synchroniser is cleared by reset, so its output only reflects the
   // pin once it has been refilled. RESYNC waits for that before trusting a
   // low strobe; otherwise a strobe held across reset would look released.
   assign settled  = (settle_q == SET_W'(SYNC_STAGES));
   assign settle_d = settled ? settle_q : settle_q + 1'b1;

   // NOTE: sequential state uses non-blocking (<=) so every register samples
   // the pre-edge value of its neighbours; blocking here would collapse the
   // synchroniser chain into a single flop.
   always_ff @(posedge clk) begin
      if (reset) begin
         stb_sync_q <= '0;
         settle_q   <= '0;
      end else begin
         stb_sync_q <= {stb_sync_q[SYNC_STAGES-2:0], i_mkr_stb};
         settle_q   <= settle_d;
      end
   end

   // ------------------------------------------------------------------
   // FIFO status (needed by the handshake to decide can_accept)
   // ------------------------------------------------------------------
   logic [LVL_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic             full, empty, pop, push;

   assign full  = (count_q == LVL_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign pop   = !empty && i_word_ready;

   // ------------------------------------------------------------------
   // Handshake FSM
   // ------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             word_last, can_accept, capture;

   assign word_last  = (idx_q == IDX_W'(WORD_BYTES - 1));
   // A word-completing byte needs a free FIFO slot; others only fill staging.
   assign can_accept = !word_last || !full;

   // NOTE: every signal written in an always_comb gets a default first, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      capture = 1'b0;
      case (state_q)
         ST_RESYNC: if (settled && !stb_s) state_d = ST_IDLE;
         ST_IDLE: begin
            // A stalled byte stays on the pins; the MCU waits for the ack.
            if (stb_s && can_accept) begin
               capture = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK:    if (!stb_s) state_d = ST_IDLE;
         default:   state_d = ST_RESYNC;
      endcase
   end

   assign o_mkr_ack = (state_q == ST_ACK);

   // ------------------------------------------------------------------
   // Packer and flush
   // ------------------------------------------------------------------
   logic [WW-1:0]         stage_q, stage_d;
   logic                  flush_pending_q, flush_pending_d;
   logic                  flush_service;
   logic [WW-1:0]         push_data;
   logic [WORD_BYTES-1:0] push_keep;
   logic [WORD_BYTES-1:0] partial_keep;

   // A capture in the same cycle wins; the flush is retried afterwards.
   assign flush_service = flush_pending_q && !capture && !full;

   always_comb begin
      partial_keep = '0;
      for (int k = 0; k < WORD_BYTES; k++) begin
         partial_keep[k] = (IDX_W'(k) < idx_q);
      end
   end

   always_comb begin
      idx_d           = idx_q;
      stage_d         = stage_q;
      push            = 1'b0;
      push_data       = stage_q;
      push_keep       = '1;
      flush_pending_d = flush_pending_q | i_flush;
      if (capture) begin
         if (word_last) begin
            push                 = 1'b1;
            push_data[WW-8 +: 8] = i_mkr_data;
            stage_d              = '0;
            idx_d                = '0;
         end else begin
            for (int k = 0; k < WORD_BYTES - 1; k++) begin
               if (idx_q == IDX_W'(k)) stage_d[8*k +: 8] = i_mkr_data;
            end
            idx_d = idx_q + 1'b1;
         end
      end else if (flush_service) begin
         // A new pulse arriving while the old one is serviced stays pending.
         flush_pending_d = i_flush;
         if (idx_q != '0) begin
            push      = 1'b1;
            push_keep = partial_keep;
            stage_d   = '0;
            idx_d     = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= ST_RESYNC;
         idx_q           <= '0;
         stage_q         <= '0;
         flush_pending_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         idx_q           <= idx_d;
         stage_q         <= stage_d;
         flush_pending_q <= flush_pending_d;
      end
   end

   // ------------------------------------------------------------------
   // Show-ahead FIFO. push is only ever raised when the FIFO is not full
   // on its pre-pop state, so a simultaneous pop never makes room early.
   // ------------------------------------------------------------------
   logic [WW-1:0]         data_mem [FIFO_DEPTH];
   logic [WORD_BYTES-1:0] keep_mem [FIFO_DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      count_d  = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; entries are only visible once
   // written, and the outputs are masked to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr_q] <= push_data;
         keep_mem[wr_ptr_q] <= push_keep;
      end
   end

   assign o_word_valid = !empty;
   assign o_word_data  = empty ? '0 : data_mem[rd_ptr_q];
   assign o_word_keep  = empty ? '0 : keep_mem[rd_ptr_q];
   assign o_fifo_level = count_q;

endmodule

// File: tb/tb_mkr_parallel_rx.sv
// ---------------------------------------------------------------------------
// Self-checking bench for mkr_parallel_rx: table-driven word vectors,
// hand-written handshake corner cases, and a randomized MCU/consumer run
// scored against a queue-based model of the packing rules.
// ---------------------------------------------------------------------------
module tb_mkr_parallel_rx;

   localparam int SYNC_STAGES = 2;
   localparam int WORD_BYTES  = 4;
   localparam int FIFO_DEPTH  = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  i_mkr_data;
   logic        i_mkr_stb;
   logic        o_mkr_ack;
   logic        i_flush;
   logic [31:0] o_word_data;
   logic [3:0]  o_word_keep;
   logic        o_word_valid;
   logic        i_word_ready;
   logic [4:0]  o_fifo_level;

   mkr_parallel_rx #(
      .SYNC_STAGES(SYNC_STAGES),
      .WORD_BYTES (WORD_BYTES),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .i_mkr_data  (i_mkr_data),
      .i_mkr_stb   (i_mkr_stb),
      .o_mkr_ack   (o_mkr_ack),
      .i_flush     (i_flush),
      .o_word_data (o_word_data),
      .o_word_keep (o_word_keep),
      .o_word_valid(o_word_valid),
      .i_word_ready(i_word_ready),
      .o_fifo_level(o_fifo_level)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic [31:0] data;
      logic [3:0]  keep;
   } word_t;

   word_t      exp_q[$];
   logic [7:0] stage_bytes[$];

   typedef struct {
      int          nbytes;
      logic [31:0] bytes;
      bit          flush;
      logic [31:0] exp_data;
      logic [3:0]  exp_keep;   // zero: no word expected
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(negedge clk);
   endtask

   // Reference model: bytes accumulate in order; a full group of
   // WORD_BYTES becomes a word, a flush emits whatever has accumulated.
   task automatic model_emit(input logic [3:0] keep);
      word_t w;
      w.data = '0;
      for (int k = 0; k < stage_bytes.size(); k++) w.data[8*k +: 8] = stage_bytes[k];
      w.keep = keep;
      exp_q.push_back(w);
      stage_bytes.delete();
   endtask

   task automatic model_byte(input logic [7:0] d);
      stage_bytes.push_back(d);
      if (stage_bytes.size() == WORD_BYTES) model_emit(4'hF);
   endtask

   task automatic model_flush();
      if (stage_bytes.size() > 0) model_emit(4'((1 << stage_bytes.size()) - 1));
   endtask

   task automatic wait_ack_low(input string name);
      for (int i = 0; i < 50 && o_mkr_ack; i++) tick();
      if (o_mkr_ack) check(name, o_mkr_ack, 0);
   endtask

   // Full 4-phase transfer of one byte; lat = negedges from strobe to ack.
   task automatic send_byte(input logic [7:0] d, output int lat);
      i_mkr_data = d;
      i_mkr_stb  = 1'b1;
      lat = 0;
      for (int i = 1; i <= 60; i++) begin
         tick();
         lat = i;
         if (o_mkr_ack) break;
      end
      if (!o_mkr_ack) check("ack_rise_timeout", o_mkr_ack, 1);
      i_mkr_stb = 1'b0;
      wait_ack_low("ack_fall_timeout");
   endtask

   task automatic mcu_byte(input logic [7:0] d);
      int lat;
      send_byte(d, lat);
      check("ack_latency", lat, SYNC_STAGES + 1);
      model_byte(d);
   endtask

   task automatic pop_one();
      i_word_ready = 1'b1;
      tick();
      i_word_ready = 1'b0;
   endtask

   task automatic drain_check(input string name);
      int budget;
      budget = 400;
      i_word_ready = 1'b1;
      while (exp_q.size() > 0 && budget > 0) begin
         if (o_word_valid) begin
            check({name, "_data"}, o_word_data, exp_q[0].data);
            check({name, "_keep"}, o_word_keep, exp_q[0].keep);
            exp_q.pop_front();
         end
         tick();
         budget--;
      end
      i_word_ready = 1'b0;
      if (exp_q.size() > 0) check({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic coincident_flush(input int n_before, input logic [31:0] exp_data,
                                   input logic [3:0] exp_keep);
      int lat;
      for (int k = 0; k < n_before; k++) send_byte(8'(k + 1), lat);
      i_mkr_data = 8'(n_before + 1);
      i_mkr_stb  = 1'b1;
      tick();
      tick();
      i_flush = 1'b1;            // same edge as the capture
      tick();
      i_flush = 1'b0;
      check("coinc_capture_ack", o_mkr_ack, 1);
      i_mkr_stb = 1'b0;
      wait_ack_low("coinc_ack_fall");
      repeat (4) tick();
      check("coinc_level", o_fifo_level, 1);
      check("coinc_data", o_word_data, exp_data);
      check("coinc_keep", o_word_keep, exp_keep);
      pop_one();
      check("coinc_level_after_pop", o_fifo_level, 0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, got running, expected done");
      $fatal(1);
   end

   int drv, gap, wait_c, left, cyc, hi, lat;
   bit abort;

   initial begin
      vecs[0] = '{4, 32'h44332211, 1'b0, 32'h44332211, 4'hF};
      vecs[1] = '{2, 32'h0000BBAA, 1'b1, 32'h0000BBAA, 4'h3};
      vecs[2] = '{0, 32'h00000000, 1'b1, 32'h00000000, 4'h0};
      vecs[3] = '{1, 32'h0000005A, 1'b1, 32'h0000005A, 4'h1};
      vecs[4] = '{3, 32'h00C0B0A0, 1'b1, 32'h00C0B0A0, 4'h7};
      vecs[5] = '{4, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF, 4'hF};
      vecs[6] = '{4, 32'h80FF0001, 1'b0, 32'h80FF0001, 4'hF};

      reset        = 1'b1;
      i_mkr_data   = 8'h00;
      i_mkr_stb    = 1'b0;
      i_flush      = 1'b0;
      i_word_ready = 1'b0;
      repeat (3) tick();
      reset = 1'b0;
      check("reset_ack",   o_mkr_ack, 0);
      check("reset_valid", o_word_valid, 0);
      check("reset_level", o_fifo_level, 0);
      check("reset_data",  o_word_data, 0);
      check("reset_keep",  o_word_keep, 0);
      repeat (4) tick();

      // ---------------- table-driven words ----------------
      for (int i = 0; i < 7; i++) begin
         for (int k = 0; k < vecs[i].nbytes; k++) begin
            send_byte(vecs[i].bytes[8*k +: 8], lat);
            check("vec_ack_latency", lat, SYNC_STAGES + 1);
         end
         if (vecs[i].flush) begin
            i_flush = 1'b1;
            tick();
            i_flush = 1'b0;
         end
         repeat (3) tick();
         check("vec_level", o_fifo_level, (vecs[i].exp_keep != 0) ? 1 : 0);
         if (vecs[i].exp_keep != 0) begin
            check("vec_data", o_word_data, vecs[i].exp_data);
            check("vec_keep", o_word_keep, vecs[i].exp_keep);
            pop_one();
            check("vec_level_after_pop", o_fifo_level, 0);
         end
      end

      // ---------------- flush coincident with capture ----------------
      coincident_flush(1, 32'h00000201, 4'h3);
      coincident_flush(3, 32'h04030201, 4'hF);   // word-completing: flush is a no-op

      // ---------------- backpressure to the MCU ----------------
      exp_q.delete();
      stage_bytes.delete();
      i_word_ready = 1'b0;
      for (int w = 0; w < FIFO_DEPTH; w++)
         for (int k = 0; k < WORD_BYTES; k++) mcu_byte(8'(w * 7 + k * 3 + 1));
      for (int k = 0; k < 3; k++) mcu_byte(8'(8'hE1 + k));
      check("bp_level_full", o_fifo_level, FIFO_DEPTH);
      i_mkr_data = 8'hE4;
      i_mkr_stb  = 1'b1;
      hi = 0;
      repeat (10) begin
         tick();
         if (o_mkr_ack) hi++;
      end
      check("bp_ack_withheld", hi, 0);
      check("bp_level_still_full", o_fifo_level, FIFO_DEPTH);
      // valid=ready=1 with a word-completing byte waiting: pop now, push next.
      i_word_ready = 1'b1;
      check("bp_head_valid", o_word_valid, 1);
      check("bp_head_data", o_word_data, exp_q[0].data);
      exp_q.pop_front();
      tick();
      i_word_ready = 1'b0;
      check("bp_level_after_pop", o_fifo_level, FIFO_DEPTH - 1);
      check("bp_ack_deferred", o_mkr_ack, 0);
      tick();
      check("bp_ack_after_pop", o_mkr_ack, 1);
      check("bp_level_refilled", o_fifo_level, FIFO_DEPTH);
      model_byte(8'hE4);
      i_mkr_stb = 1'b0;
      wait_ack_low("bp_ack_fall");
      drain_check("bp_drain");
      tick();
      check("bp_level_empty", o_fifo_level, 0);

      // ---------------- strobe held across reset ----------------
      i_mkr_data = 8'h77;
      i_mkr_stb  = 1'b1;
      repeat (2) tick();
      reset = 1'b1;
      repeat (5) tick();
      reset = 1'b0;
      exp_q.delete();
      stage_bytes.delete();
      hi = 0;
      repeat (12) begin
         tick();
         if (o_mkr_ack) hi++;
      end
      check("resync_no_ack", hi, 0);
      check("resync_level", o_fifo_level, 0);
      i_mkr_stb = 1'b0;
      repeat (4) tick();
      mcu_byte(8'h10);
      mcu_byte(8'h20);
      mcu_byte(8'h30);
      mcu_byte(8'h40);
      tick();
      check("resync_level_word", o_fifo_level, 1);
      drain_check("resync_word");

      // ---------------- randomized run against the model ----------------
      drv = 0; gap = 2; wait_c = 0; left = 400; cyc = 0; abort = 1'b0;
      while ((left > 0 || drv != 0) && !abort && cyc < 20000) begin
         i_flush = 1'b0;
         case (drv)
            0: begin
               if (gap > 0) begin
                  gap--;
               end else if ($urandom_range(0, 7) == 0 && o_fifo_level < FIFO_DEPTH) begin
                  // No strobe in flight and level can only fall, so the flush
                  // is serviced before the next byte can be captured.
                  i_flush = 1'b1;
                  model_flush();
                  gap = 1;
               end else begin
                  i_mkr_data = 8'($urandom);
                  i_mkr_stb  = 1'b1;
                  drv = 1;
                  wait_c = 0;
                  left--;
               end
            end
            1: begin
               if (o_mkr_ack) begin
                  model_byte(i_mkr_data);
                  i_mkr_stb = 1'b0;
                  drv = 2;
                  wait_c = 0;
               end else begin
                  wait_c++;
                  if (wait_c > 400) begin
                     check("rand_ack_rise_timeout", o_mkr_ack, 1);
                     abort = 1'b1;
                  end
               end
            end
            default: begin
               if (!o_mkr_ack) begin
                  drv = 0;
                  gap = $urandom_range(0, 3);
               end else begin
                  wait_c++;
                  if (wait_c > 50) begin
                     check("rand_ack_fall_timeout", o_mkr_ack, 0);
                     abort = 1'b1;
                  end
               end
            end
         endcase
         i_word_ready = 1'($urandom_range(0, 1));
         if (o_word_valid && i_word_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_unexpected_word", o_word_valid, 0);
            end else begin
               check("rand_word_data", o_word_data, exp_q[0].data);
               check("rand_word_keep", o_word_keep, exp_q[0].keep);
               exp_q.pop_front();
            end
         end
         tick();
         cyc++;
      end
      i_word_ready = 1'b0;
      i_mkr_stb    = 1'b0;
      if (cyc >= 20000) check("rand_cycle_budget", cyc, 0);
      model_flush();
      i_flush = 1'b1;
      tick();
      i_flush = 1'b0;
      drain_check("rand_drain");
      repeat (3) tick();
      check("final_level", o_fifo_level, 0);
      check("final_valid", o_word_valid, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mkr_parallel_rx.md
Name: mkr_parallel_rx

Overview:
- Receive stage between the SAM D21 MCU and the Cicero user logic.
- The MCU pushes bytes over MKR header pins using an asynchronous 4-phase strobe/ack handshake.
- The block synchronises the strobe, captures each byte, packs bytes little-endian into words, and buffers the words in a show-ahead FIFO.
- The FIFO feeds the regex engine's program/data loader through a valid/ready interface.

Parameters:
- SYNC_STAGES, 2, flip-flop stages on the asynchronous strobe input (min 2).
- WORD_BYTES, 4, bytes per output word.
- FIFO_DEPTH, 16, output FIFO entries; power of two, min 2.

Ports:
- clk  in  1  system clock (48 MHz domain).
- reset  in  1  synchronous, active-high reset.
- i_mkr_data  in  8  byte from MCU; stable from strobe rise until ack rise.
- i_mkr_stb  in  1  asynchronous strobe from MCU; high = byte presented.
- o_mkr_ack  out  1  acknowledge to MCU.
- i_flush  in  1  single-cycle pulse; emit any partial word.
- o_word_data  out  8*WORD_BYTES  FIFO head word.
- o_word_keep  out  WORD_BYTES  byte-valid mask of the head word.
- o_word_valid  out  1  FIFO not empty.
- i_word_ready  in  1  consumer accepts the head word.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (reset=1 at a clk edge):
  - o_mkr_ack=0, o_word_valid=0, o_fifo_level=0, o_word_data=0, o_word_keep=0.
  - Byte index=0, pending flush cleared, synchroniser cleared.
  - FSM forced to RESYNC.
- Strobe sync: stb_s is i_mkr_stb after SYNC_STAGES flops. i_mkr_data is sampled directly; the protocol guarantees it is stable.
- Handshake FSM:
  - RESYNC: ack=0; go to IDLE when stb_s==0. This prevents double capture of a strobe held across reset.
  - IDLE: ack=0. If stb_s==1 and can_accept, capture the byte, ack<=1, go to ACK. Otherwise stay and stall without dropping the byte.
  - ACK: ack=1; when stb_s==0, ack<=0 and go to IDLE.
- can_accept: byte index < WORD_BYTES-1, or the FIFO is not full. A word-completing byte needs a free FIFO slot.
- Latency: strobe rise at pin → ack high after SYNC_STAGES+1 clk edges (FIFO not full).
- Packer:
  - A byte at index k goes to bits [8k+7:8k] of the staging word, and index increments.
  - When k==WORD_BYTES-1, at the same edge: the full word is written to the FIFO with keep=all ones, staging is cleared, and index becomes 0.
  - o_word_valid rises in the cycle after that edge.
- Flush:
  - An i_flush pulse sets flush_pending.
  - It is serviced in the first cycle with no capture and the FIFO not full.
  - If index>0: push the staging word with upper bytes zero, keep = (1<<index)-1, then index=0.
  - If index==0: no push.
  - flush_pending clears when serviced.
  - Flush coincident with a capture: the capture wins and the flush is serviced later, so the flush includes that byte unless the byte completed the word, in which case the flush is a no-op.
- FIFO:
  - Show-ahead: head on o_word_data/o_word_keep whenever o_word_valid=1.
  - Pop on valid&&ready.
  - Full is judged on pre-pop state; no push when full even if popping in the same cycle.
  - Push and pop in the same cycle: level unchanged.
  - Read and write pointers wrap modulo FIFO_DEPTH.
  - Ready while empty: no effect.
- Overflow is impossible by construction; backpressure propagates to the MCU via a withheld ack.

Test Plan:
- Reset, then MCU sends bytes 0x11,0x22,0x33,0x44 → one word 0x44332211, keep=0xF, o_fifo_level=1; each ack rises 3 clk after its strobe rise.
- Send 0xAA,0xBB then pulse i_flush → word 0x0000BBAA, keep=0x3; a second flush with index 0 pushes nothing.
- i_word_ready=0, send 16 words plus 3 more bytes → level 16. The 3 bytes are acked, but ack for the 4th byte stays 0. Assert ready for 1 cycle → level 15, 4th byte acked, level returns to 16.
- Hold i_mkr_stb high, assert reset 5 cycles, release → no capture and ack=0 until strobe falls; the next strobe captures normally.
- Full FIFO with valid=ready=1 and a word-completing byte pending → pop occurs, push deferred one cycle, level 16→15→16.
- i_flush in the same cycle as capture of the 2nd byte (0x01,0x02) → word 0x00000201, keep=0x3 pushed a later cycle.
